// File: rtl/nmr_bstrm_pulse_seq.sv
// NMR pulse sequencer: pops 32-bit bitstream words from an FWFT FIFO and plays
// them as pulse-line patterns with per-word hold times. Optional word counter: NMR_PSEQ_WORDCNT_EN.
module nmr_bstrm_pulse_seq #(
  parameter int BUS_WIDTH = 32,
  parameter int OUT_WIDTH = 7,
  parameter int CNT_WIDTH = 24
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [BUS_WIDTH-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_rd,
  output logic [OUT_WIDTH-1:0] pulse_out,
  output logic                 BUSY,
  output logic                 D_END,
  output logic                 underrun
`ifdef NMR_PSEQ_WORDCNT_EN
  ,
  output logic [15:0]          word_cnt
`endif
);

  generate
    if (OUT_WIDTH + CNT_WIDTH > BUS_WIDTH - 1) begin : g_bad_widths
      $error("nmr_bstrm_pulse_seq: OUT_WIDTH + CNT_WIDTH must not exceed BUS_WIDTH - 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [OUT_WIDTH-1:0] pulse_n;
  logic                 more_r, more_n;
  logic                 underrun_n;

  logic                 w_more;
  logic [OUT_WIDTH-1:0] w_pat;
  logic [CNT_WIDTH-1:0] w_dur;
  logic                 unused_word_bits;

  assign w_more           = word_in[BUS_WIDTH-1];
  assign w_pat            = word_in[BUS_WIDTH-2 -: OUT_WIDTH];
  assign w_dur            = word_in[CNT_WIDTH-1:0];
  assign unused_word_bits = ^word_in;

  // A word loaded on the edge where cnt reaches zero keeps the lines busy with no gap;
  // every path into DONE drops the lines on that same edge.
  always_comb begin
    state_n    = state;
    pulse_n    = pulse_out;
    cnt_n      = cnt;
    more_n     = more_r;
    underrun_n = underrun;
    word_rd    = 1'b0;
    case (state)
      IDLE: begin
        pulse_n = '0;
        if (START && !STOP) begin
          state_n    = LOAD;
          underrun_n = 1'b0;
        end
      end
      LOAD: begin
        if (STOP) begin
          pulse_n = '0;
          state_n = DONE;
        end else if (word_valid) begin
          word_rd = 1'b1;
          pulse_n = w_pat;
          cnt_n   = w_dur;
          more_n  = w_more;
          state_n = RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          pulse_n = '0;
          state_n = DONE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end else if (more_r && word_valid) begin
          word_rd = 1'b1;
          pulse_n = w_pat;
          cnt_n   = w_dur;
          more_n  = w_more;
        end else begin
          if (more_r) underrun_n = 1'b1;
          pulse_n = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        pulse_n = '0;
        state_n = IDLE;
      end
      default: begin
        pulse_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // D_END and BUSY are registered from the next state so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pulse_out <= '0;
      cnt       <= '0;
      more_r    <= 1'b0;
      D_END     <= 1'b0;
      BUSY      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_n;
      pulse_out <= pulse_n;
      cnt       <= cnt_n;
      more_r    <= more_n;
      D_END     <= (state_n == DONE);
      BUSY      <= (state_n != IDLE);
      underrun  <= underrun_n;
    end
  end

`ifdef NMR_PSEQ_WORDCNT_EN
  // Kept after the sequence ends so the SoC can read back how many words were played.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt <= 16'd0;
    end else if (state == IDLE && state_n == LOAD) begin
      word_cnt <= 16'd0;
    end else if (word_rd && word_cnt != 16'hFFFF) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nmr_bstrm_pulse_seq.sv
// Directed bench for nmr_bstrm_pulse_seq with a small FWFT FIFO model feeding it.
// Word-counter checks are compiled in only when NMR_PSEQ_WORDCNT_EN is defined.
module tb_nmr_bstrm_pulse_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [31:0] word_in = 32'd0;
  logic        word_valid = 1'b0;
  logic        word_rd;
  logic [6:0]  pulse_out;
  logic        BUSY;
  logic        D_END;
  logic        underrun;
`ifdef NMR_PSEQ_WORDCNT_EN
  logic [15:0] word_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int rd_mark;

  always #5 CLK = ~CLK;

  nmr_bstrm_pulse_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .STOP       (STOP),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_rd    (word_rd),
    .pulse_out  (pulse_out),
    .BUSY       (BUSY),
    .D_END      (D_END),
    .underrun   (underrun)
`ifdef NMR_PSEQ_WORDCNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  task automatic refreshFifo();
    word_valid = (rd_ptr < wr_ptr);
    word_in    = word_valid ? fifo_mem[rd_ptr] : 32'd0;
  endtask

  task automatic pushWord(input logic [31:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
    refreshFifo();
  endtask

  task automatic flushFifo();
    rd_ptr = wr_ptr;
    refreshFifo();
  endtask

  // Drive START/STOP for one edge; the model pops if word_rd was high just before it.
  task automatic applyStimulus(input logic s, input logic p);
    logic popped;
    START = s;
    STOP  = p;
    #3;
    popped = word_rd;
    @(posedge CLK);
    #1;
    if (popped) begin
      rd_ptr++;
      rd_count++;
    end
    START = 1'b0;
    STOP  = 1'b0;
    refreshFifo();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    RST = 1'b0;
    checkOutput("rst_pulse", 32'(pulse_out), 32'h0);
    checkOutput("rst_busy", 32'(BUSY), 32'h0);
    checkOutput("rst_dend", 32'(D_END), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
`ifdef NMR_PSEQ_WORDCNT_EN
    checkOutput("rst_wcnt", 32'(word_cnt), 32'h0);
`endif

    // Basic two-word sequence
    pushWord(32'h8500_0003);
    pushWord(32'h7F00_0001);
    #2;
    checkOutput("idle_no_rd", 32'(word_rd), 32'h0);
    rd_mark = rd_count;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_load_busy", 32'(BUSY), 32'h1);
    checkOutput("t1_load_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t1_load_rd", 32'(word_rd), 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("t1_pat05_%0d", i), 32'(pulse_out), 32'h05);
      checkOutput($sformatf("t1_busy05_%0d", i), 32'(BUSY), 32'h1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("t1_pat7f_%0d", i), 32'(pulse_out), 32'h7F);
      checkOutput($sformatf("t1_dend7f_%0d", i), 32'(D_END), 32'h0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_done_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t1_done_dend", 32'(D_END), 32'h1);
    checkOutput("t1_done_busy", 32'(BUSY), 32'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_idle_dend", 32'(D_END), 32'h0);
    checkOutput("t1_idle_busy", 32'(BUSY), 32'h0);
    checkOutput("t1_rd_count", 32'(rd_count - rd_mark), 32'd2);
    checkOutput("t1_underrun", 32'(underrun), 32'h0);
`ifdef NMR_PSEQ_WORDCNT_EN
    checkOutput("t1_wcnt", 32'(word_cnt), 32'd2);
`endif

    // Late first word
    applyStimulus(1'b1, 1'b0);
`ifdef NMR_PSEQ_WORDCNT_EN
    checkOutput("t2_wcnt_clear", 32'(word_cnt), 32'd0);
`endif
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("t2_wait_busy_%0d", i), 32'(BUSY), 32'h1);
      checkOutput($sformatf("t2_wait_pulse_%0d", i), 32'(pulse_out), 32'h0);
    end
    pushWord(32'h0100_0000);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_pat01", 32'(pulse_out), 32'h01);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_done_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t2_done_dend", 32'(D_END), 32'h1);
    checkOutput("t2_underrun", 32'(underrun), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_idle_busy", 32'(BUSY), 32'h0);

    // Underrun
    pushWord(32'h8300_0002);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("t3_pat03_%0d", i), 32'(pulse_out), 32'h03);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_done_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t3_done_dend", 32'(D_END), 32'h1);
    checkOutput("t3_underrun_set", 32'(underrun), 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("t3_underrun_hold_%0d", i), 32'(underrun), 32'h1);
    end
    checkOutput("t3_idle_busy", 32'(BUSY), 32'h0);

    // Abort with STOP, START ignored while busy
    pushWord(32'h0A00_0064);
    rd_mark = rd_count;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_underrun_clear", 32'(underrun), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_pat0a", 32'(pulse_out), 32'h0A);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_start_ignored_pulse", 32'(pulse_out), 32'h0A);
    checkOutput("t4_start_ignored_busy", 32'(BUSY), 32'h1);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("t4_pat0a_late", 32'(pulse_out), 32'h0A);
    pushWord(32'h0100_0000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t4_stop_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t4_stop_dend", 32'(D_END), 32'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_dend_once", 32'(D_END), 32'h0);
    checkOutput("t4_idle_busy", 32'(BUSY), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_dend_quiet", 32'(D_END), 32'h0);
    checkOutput("t4_rd_count", 32'(rd_count - rd_mark), 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t4_stop_beats_start", 32'(BUSY), 32'h0);
    checkOutput("t4_no_rd_idle", 32'(rd_count - rd_mark), 32'd1);

    // Reset mid-RUN
    flushFifo();
    pushWord(32'h0500_FFFF);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_pat05", 32'(pulse_out), 32'h05);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
    RST = 1'b1;
    applyStimulus(1'b0, 1'b0);
    RST = 1'b0;
    checkOutput("t5_rst_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t5_rst_busy", 32'(BUSY), 32'h0);
    checkOutput("t5_rst_dend", 32'(D_END), 32'h0);
    checkOutput("t5_rst_underrun", 32'(underrun), 32'h0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_post_rst_dend", 32'(D_END), 32'h0);
    flushFifo();
    pushWord(32'h7F00_0000);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_pat7f", 32'(pulse_out), 32'h7F);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_done_pulse", 32'(pulse_out), 32'h0);
    checkOutput("t5_done_dend", 32'(D_END), 32'h1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_idle_busy", 32'(BUSY), 32'h0);
`ifdef NMR_PSEQ_WORDCNT_EN
    checkOutput("t5_wcnt", 32'(word_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmr_bstrm_pulse_seq.md
Name: nmr_bstrm_pulse_seq

Overview:
- Downstream consumer of the bitstream FIFO stage. Pops 32-bit bitstream words from a first-word-fall-through (FWFT) FIFO interface.
- Each word is decoded into a level pattern on the NMR pulse-control lines plus a hold duration in clock cycles.
- Plays words back-to-back with no gap cycles until a word with the "more" flag cleared.
- Signals sequence completion to the SoC via D_END.

Parameters:
- BUS_WIDTH, 32, word width; MSB is the "more" flag.
- OUT_WIDTH, 7, pulse-control lines; field is [BUS_WIDTH-2 -: OUT_WIDTH].
- CNT_WIDTH, 24, duration field [CNT_WIDTH-1:0]; elaboration must enforce OUT_WIDTH+CNT_WIDTH <= BUS_WIDTH-1.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- START  in  1  level-sampled; begins a sequence when idle.
- STOP  in  1  level-sampled abort from the SoC.
- word_in  in  BUS_WIDTH  FWFT FIFO head word.
- word_valid  in  1  word_in valid (FIFO not empty).
- word_rd  out  1  combinational pop strobe; consumes word_in at this edge.
- pulse_out  out  OUT_WIDTH  registered pulse-control levels.
- BUSY  out  1  registered; high when state != IDLE.
- D_END  out  1  registered, one-cycle end-of-sequence pulse.
- underrun  out  1  sticky; FIFO was empty when a continuation word was needed.

Behaviour:
- Reset (RST high at an edge): state=IDLE, pulse_out=0, cnt=0, more_r=0, D_END=0, underrun=0. BUSY=0 and word_rd=0 follow from state=IDLE. RST has priority over all other inputs.
- Word fields: more=word[BUS_WIDTH-1]; pat=word[BUS_WIDTH-2 -: OUT_WIDTH]; dur=word[CNT_WIDTH-1:0]; unused bits ignored.
- Hold time: a word holds pat on pulse_out for exactly dur+1 cycles. dur=0 gives 1 cycle.
- IDLE: pulse_out=0.
  - START=1 and STOP=0 -> LOAD; underrun cleared on this edge.
- LOAD: waits indefinitely for the first word.
  - word_rd = word_valid.
  - On an edge with word_valid=1: pulse_out<=pat, cnt<=dur, more_r<=more -> RUN.
- RUN:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0 and more_r=1 and word_valid=1: word_rd=1, load the new word as in LOAD, stay in RUN. This is seamless: no idle cycle between words.
  - cnt==0 and more_r=1 and word_valid=0: underrun<=1 -> DONE.
  - cnt==0 and more_r=0 -> DONE.
- DONE: pulse_out<=0, D_END<=1 for exactly one cycle -> IDLE.
- Latency: START high at edge t -> state=LOAD after t. If word_valid is already high, pulse_out=pat after edge t+1 and BUSY=1 after edge t.
- STOP=1 in LOAD or RUN: word_rd=0; next edge pulse_out<=0 -> DONE (D_END pulses). STOP in IDLE or DONE: no effect. STOP has priority over START and over word loading.
- START while BUSY: ignored.
- word_rd is never asserted in IDLE or DONE, or while word_valid=0.
- RST mid-sequence: outputs return to reset values at that edge; no D_END is generated. The FIFO is not flushed by this block.

Optional Feature:
- Macro: NMR_PSEQ_WORDCNT_EN.
- Defined: adds output word_cnt [15:0], registered. Reset to 0 and cleared on the IDLE->LOAD edge. Increments on every edge with word_rd=1; saturates at 16'hFFFF. Held after the sequence ends for SoC readback.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Basic two-word sequence: FIFO holds 32'h8500_0003, 32'h7F00_0001, word_valid high; START pulse for one cycle.
  - Required: pulse_out=7'h05 for 4 cycles, then 7'h7F for 2 cycles, then 0.
  - word_rd high exactly 2 cycles; D_END single pulse on the cycle after the last 7'h7F cycle; BUSY high throughout.
- Late first word: START with FIFO empty, first word 32'h0100_0000 arrives 10 cycles later.
  - Required: BUSY=1 while waiting, pulse_out=0; then 7'h01 for 1 cycle, D_END pulse, underrun=0.
- Underrun: single word 32'h8300_0002 followed by an empty FIFO.
  - Required: 7'h03 for 3 cycles, then pulse_out=0, D_END pulse, underrun=1 held until the next START.
- Abort: 32'h0A00_0064 (dur 100), STOP asserted 20 cycles into RUN.
  - Required: pulse_out=0 on the next edge, one D_END pulse, no further word_rd.
  - START asserted while BUSY earlier in the run has no effect.
- Reset mid-RUN: RST=1 for 1 cycle during a long word.
  - Required: pulse_out=0, BUSY=0, D_END=0, underrun=0 after that edge.
  - Then a fresh START plays 32'h7F00_0000 normally for 1 cycle.
- With NMR_PSEQ_WORDCNT_EN: replay the basic two-word sequence.
  - Required: word_cnt=2 after D_END; cleared to 0 on the next START.
